// File: rtl/ctrl_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ctrl_sequencer
// Brief    : Fetch/wait/execute controller for the 8-bit accumulator softcore.
//            Owns the PC, fetches over a req/valid handshake, decodes each
//            instruction into a one-hot ALU mode plus operand selects and
//            write strobes, and resolves branches from latched ALU flags.
// Options  : CTRL_SEQ_IMEM_TIMEOUT_EN - bound the WAIT state to TIMEOUT_CYCLES;
//            on expiry pulse illegal and halt.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT 7
`endif
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 2
`endif

module ctrl_sequencer #(
  parameter int          BIT_COUNT      = 8,
  parameter int unsigned RESET_PC       = 0,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  output logic                       imem_req,
  output logic [BIT_COUNT-1:0]       imem_addr,
  input  logic                       imem_valid,
  input  logic [BIT_COUNT-1:0]       imem_rdata,
  output logic [`ALU_MODE_COUNT-1:0] alu_mode,
  input  logic [`ALU_FLAG_COUNT-1:0] alu_flags,
  output logic                       b_sel_imm,
  output logic [3:0]                 imm,
  output logic [2:0]                 rf_raddr,
  output logic [2:0]                 rf_waddr,
  output logic                       rf_we,
  output logic                       acc_we,
  output logic [BIT_COUNT-1:0]       pc,
  output logic                       halted,
  output logic                       illegal
);

  // One-hot bit positions within alu_mode
  localparam int c_MODE_ADD    = 0;
  localparam int c_MODE_SHIFT  = 1;
  localparam int c_MODE_NOT    = 2;
  localparam int c_MODE_AND    = 3;
  localparam int c_MODE_OR     = 4;
  localparam int c_MODE_XOR    = 5;
  localparam int c_MODE_BYPASS = 6;

  // Flag positions within alu_flags / r_flags_q
  localparam int c_FLAG_EQ = 0;
  localparam int c_FLAG_GT = 1;

  localparam logic [BIT_COUNT-1:0] c_RESET_PC = BIT_COUNT'(RESET_PC);
  localparam logic [BIT_COUNT-1:0] c_PC_ONE   = BIT_COUNT'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_next_state;
  logic [BIT_COUNT-1:0]         r_pc;
  logic [BIT_COUNT-1:0]         w_pc_next;
  logic [BIT_COUNT-1:0]         r_ir;
  logic [`ALU_FLAG_COUNT-1:0]   r_flags_q;
  logic                         w_ir_load;
  logic                         w_flags_load;
  logic                         w_illegal;
  logic [3:0]                   w_opcode;
  logic [BIT_COUNT-1:0]         w_offset;

  assign w_opcode = r_ir[7:4];
  // Branch offset is the low nibble, sign-extended to PC width
  assign w_offset = {{(BIT_COUNT-4){r_ir[3]}}, r_ir[3:0]};

`ifdef CTRL_SEQ_IMEM_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [c_CNT_W-1:0] r_wait_cnt;

  // Wait counter: cleared while requesting, counts each cycle spent in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_FETCH) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
    end
  end
`endif

  // State, PC, instruction and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= c_RESET_PC;
      r_ir      <= '0;
      r_flags_q <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_ir_load) begin
        r_ir <= imem_rdata;
      end
      if (w_flags_load) begin
        r_flags_q <= alu_flags;
      end
    end
  end

  // Next-state, decode and strobe generation
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ir_load    = 1'b0;
    w_flags_load = 1'b0;
    w_illegal    = 1'b0;
    imem_req     = 1'b0;
    alu_mode     = '0;
    b_sel_imm    = 1'b0;
    rf_we        = 1'b0;
    acc_we       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_req     = 1'b1;
        w_next_state = S_WAIT;
      end

      S_WAIT: begin
        if (imem_valid) begin
          w_ir_load    = 1'b1;
          w_next_state = S_EXEC;
        end
`ifdef CTRL_SEQ_IMEM_TIMEOUT_EN
        else if (r_wait_cnt == c_CNT_LAST) begin
          w_illegal    = 1'b1;
          w_next_state = S_HALT;
        end
`endif
      end

      S_EXEC: begin
        w_next_state = S_FETCH;
        w_pc_next    = r_pc + c_PC_ONE;
        case (w_opcode)
          4'h1: begin alu_mode[c_MODE_ADD]   = 1'b1; acc_we = 1'b1; end
          4'h2: begin alu_mode[c_MODE_ADD]   = 1'b1; b_sel_imm = 1'b1; acc_we = 1'b1; end
          4'h3: begin alu_mode[c_MODE_SHIFT] = 1'b1; acc_we = 1'b1; end
          4'h4: begin alu_mode[c_MODE_SHIFT] = 1'b1; b_sel_imm = 1'b1; acc_we = 1'b1; end
          4'h5: begin alu_mode[c_MODE_NOT]   = 1'b1; acc_we = 1'b1; end
          4'h6: begin alu_mode[c_MODE_AND]   = 1'b1; acc_we = 1'b1; end
          4'h7: begin alu_mode[c_MODE_OR]    = 1'b1; acc_we = 1'b1; end
          4'h8: begin
            alu_mode[c_MODE_XOR] = 1'b1;
            acc_we               = 1'b1;
            w_flags_load         = 1'b1;
          end
          4'h9: begin
            // r7 is reserved as a destination: the write is dropped
            alu_mode[c_MODE_BYPASS] = 1'b1;
            rf_we                   = (r_ir[2:0] != 3'd7);
          end
          4'hA: begin
            if (r_flags_q[c_FLAG_EQ]) begin
              w_pc_next = r_pc + w_offset;
            end
          end
          4'hB: begin
            if (r_flags_q[c_FLAG_GT]) begin
              w_pc_next = r_pc + w_offset;
            end
          end
          4'hC: w_pc_next = r_pc + w_offset;
          4'hD, 4'hE: w_illegal = 1'b1;
          4'hF: begin
            w_pc_next    = r_pc;
            w_next_state = S_HALT;
          end
          default: ;
        endcase
      end

      S_HALT: ;

      default: w_next_state = S_IDLE;
    endcase
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign imm       = r_ir[3:0];
  assign rf_raddr  = r_ir[2:0];
  assign rf_waddr  = r_ir[2:0];
  assign halted    = (r_state == S_HALT);
  assign illegal   = w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ctrl_sequencer
// Brief    : Directed self-checking bench for ctrl_sequencer. Expected decode
//            results come from a small instruction model and are queued when
//            an instruction is issued, then compared in its EXEC cycle.
//            Build with +define+CTRL_SEQ_IMEM_TIMEOUT_EN for the timeout case.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic [6:0] alu_mode;
  logic [1:0] alu_flags = 2'b00;
  logic       b_sel_imm;
  logic [3:0] imm;
  logic [2:0] rf_raddr;
  logic [2:0] rf_waddr;
  logic       rf_we;
  logic       acc_we;
  logic [7:0] pc;
  logic       halted;
  logic       illegal;

  ctrl_sequencer #(.BIT_COUNT(8), .RESET_PC(0), .TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .alu_mode   (alu_mode),
    .alu_flags  (alu_flags),
    .b_sel_imm  (b_sel_imm),
    .imm        (imm),
    .rf_raddr   (rf_raddr),
    .rf_waddr   (rf_waddr),
    .rf_we      (rf_we),
    .acc_we     (acc_we),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [6:0] mode;
    logic       bsel;
    logic [3:0] imm;
    logic [2:0] ra;
    logic       acc_we;
    logic       rf_we;
    logic       ill;
    logic [7:0] pc_next;
    logic       halt;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic [7:0] m_pc = 8'h00;
  logic [1:0] m_flags = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode of one instruction against the model PC and flags
  function automatic exp_t model(input logic [7:0] instr, input logic [1:0] live_flags);
    exp_t e;
    logic [3:0] op;
    logic [7:0] off;
    op = instr[7:4];
    off = {{4{instr[3]}}, instr[3:0]};
    e.addr = m_pc; e.mode = 7'd0; e.bsel = 1'b0; e.imm = instr[3:0];
    e.ra = instr[2:0]; e.acc_we = 1'b0; e.rf_we = 1'b0; e.ill = 1'b0;
    e.pc_next = m_pc + 8'd1; e.halt = 1'b0;
    case (op)
      4'h1, 4'h2: e.mode = 7'b0000001;
      4'h3, 4'h4: e.mode = 7'b0000010;
      4'h5: e.mode = 7'b0000100;
      4'h6: e.mode = 7'b0001000;
      4'h7: e.mode = 7'b0010000;
      4'h8: e.mode = 7'b0100000;
      4'h9: e.mode = 7'b1000000;
      default: e.mode = 7'd0;
    endcase
    e.bsel   = (op == 4'h2) || (op == 4'h4);
    e.acc_we = (op >= 4'h1) && (op <= 4'h8);
    e.rf_we  = (op == 4'h9) && (instr[2:0] != 3'd7);
    e.ill    = (op == 4'hD) || (op == 4'hE);
    if ((op == 4'hA && m_flags[0]) || (op == 4'hB && m_flags[1]) || op == 4'hC)
      e.pc_next = m_pc + off;
    if (op == 4'hF) begin
      e.pc_next = m_pc;
      e.halt = 1'b1;
    end
    if (op == 4'h8) m_flags = live_flags;
    m_pc = e.pc_next;
    return e;
  endfunction

  task automatic do_reset();
    run = 1'b0;
    imem_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem_req, 1'b0);
    check("rst_mode", alu_mode, 7'd0);
    check("rst_strobes", {acc_we, rf_we, b_sel_imm, halted, illegal}, 5'd0);
    rst_n = 1'b1;
    m_pc = 8'h00;
    m_flags = 2'b00;
  endtask

  task automatic issue(input logic [7:0] instr, input logic [1:0] flg);
    exp_t e;
    int n;
    q_exp.push_back(model(instr, flg));
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_seen", imem_req, 1'b1);
    check("imem_addr", imem_addr, q_exp[0].addr);
    imem_valid = 1'b1;
    imem_rdata = instr;
    alu_flags  = flg;
    step();                       // WAIT, valid present
    step();                       // EXEC
    imem_valid = 1'b0;
    imem_rdata = 8'h00;
    e = q_exp.pop_front();
    check($sformatf("mode_%02h", instr), alu_mode, e.mode);
    check($sformatf("bsel_%02h", instr), b_sel_imm, e.bsel);
    check($sformatf("imm_%02h", instr), imm, e.imm);
    check($sformatf("raddr_%02h", instr), rf_raddr, e.ra);
    check($sformatf("acc_we_%02h", instr), acc_we, e.acc_we);
    check($sformatf("rf_we_%02h", instr), rf_we, e.rf_we);
    check($sformatf("illegal_%02h", instr), illegal, e.ill);
    check($sformatf("exec_req_%02h", instr), imem_req, 1'b0);
    step();
    check($sformatf("pc_after_%02h", instr), pc, e.pc_next);
    check($sformatf("halted_%02h", instr), halted, e.halt);
    check($sformatf("illegal_clr_%02h", instr), illegal, 1'b0);
  endtask

  initial begin
    int reqs;
    int k_ill;
    int n_ill;
    int k_halt;

    // ADDI 3 from reset
    do_reset();
    run = 1'b1;
    step();
    check("first_req", imem_req, 1'b1);
    issue(8'h23, 2'b00);

    // XOR latches EQ, BEQ -2 wraps below zero, NOP wraps back to 0
    do_reset();
    run = 1'b1;
    issue(8'h82, 2'b01);
    issue(8'hAE, 2'b00);
    issue(8'h00, 2'b00);
    issue(8'hC7, 2'b00);
    issue(8'hC7, 2'b00);
    issue(8'h00, 2'b00);
    run = 1'b0;                   // ignored outside IDLE
    issue(8'h00, 2'b00);
    issue(8'hB4, 2'b10);          // flags_q[GT]=0 -> not taken
    issue(8'h97, 2'b00);
    issue(8'hD0, 2'b00);
    issue(8'hE5, 2'b00);
    issue(8'h93, 2'b00);
    issue(8'h15, 2'b00);
    issue(8'h35, 2'b00);
    issue(8'h41, 2'b00);
    issue(8'h50, 2'b00);
    issue(8'h66, 2'b00);
    issue(8'h71, 2'b00);
    issue(8'h8A, 2'b10);          // flags_q <= GT
    issue(8'hB4, 2'b00);          // taken
    issue(8'hA2, 2'b01);          // live EQ ignored, flags_q[EQ]=0
    issue(8'h1C, 2'b11);          // flags_q must not change
    issue(8'hB1, 2'b00);          // still GT -> taken

    // HALT at 0x05 holds pc and stops fetching
    do_reset();
    run = 1'b1;
    issue(8'hC5, 2'b00);
    issue(8'hF0, 2'b00);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req) reqs++;
    end
    check("halt_no_req", reqs, 0);
    check("halt_pc", pc, 8'h05);
    check("halt_flag", halted, 1'b1);

    // Asynchronous reset in the middle of WAIT, then a late valid
    do_reset();
    run = 1'b1;
    issue(8'h00, 2'b00);          // pc -> 1
    check("mid_req", imem_req, 1'b1);
    step();                       // WAIT with no valid
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", pc, 8'h00);
    check("async_req", imem_req, 1'b0);
    check("async_halted", halted, 1'b0);
    run = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 8'h23;
    step();
    rst_n = 1'b1;
    step();
    step();
    imem_valid = 1'b0;
    check("late_valid_imm", imm, 4'h0);
    check("late_valid_mode", alu_mode, 7'd0);
    check("late_valid_acc", acc_we, 1'b0);
    check("late_valid_req", imem_req, 1'b0);
    check("late_valid_pc", pc, 8'h00);

    // WAIT with no valid at all
    do_reset();
    run = 1'b1;
    step();
    check("to_req", imem_req, 1'b1);
    k_ill = 0; n_ill = 0; k_halt = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (illegal) begin
        n_ill++;
        k_ill = k;
      end
      if (halted && k_halt == 0) k_halt = k;
    end
`ifdef CTRL_SEQ_IMEM_TIMEOUT_EN
    check("to_ill_cycle", k_ill, 15);
    check("to_ill_count", n_ill, 1);
    check("to_halt_cycle", k_halt, 16);
`else
    check("nto_ill_count", n_ill, 0);
    check("nto_halted", k_halt, 0);
    check("nto_pc", pc, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
